// File: rtl/hsys_mem_pkg.sv
// hsys_mem_pkg: op codes, FSM states and default widths shared by the RAM engine
package hsys_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 11;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_COPY  = 2'd1,
        OP_CHECK = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_RDW,
        S_WR,
        S_CMP,
        S_DONE
    } state_t;

endpackage

// File: rtl/hsys_mem_patgen.sv
// hsys_mem_patgen: pattern for the current word of a job, either pattern+i or a constant
module hsys_mem_patgen #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] pattern,
    input  logic              incr,
    output logic [DATA_W-1:0] pat,
    output logic [DATA_W-1:0] pat_nxt
);

    logic incr_q;

    assign pat_nxt = pat + DATA_W'(incr_q);

    // Load word 0 when a command is accepted, then advance one word per step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat    <= '0;
            incr_q <= 1'b0;
        end else if (load) begin
            pat    <= pattern;
            incr_q <= incr;
        end else if (step) begin
            pat    <= pat_nxt;
        end
    end

endmodule

// File: rtl/hsys_mem_engine.sv
// hsys_mem_engine: Avalon-MM host running FILL, COPY and CHECK jobs on the on-chip RAM.
// Define HSYS_MEM_ERRLOG_EN to add err_valid/err_addr/err_data, a log of the first CHECK mismatch.
module hsys_mem_engine
    import hsys_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [CNT_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    input  logic                cmd_incr,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_count,
`ifdef HSYS_MEM_ERRLOG_EN
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [DATA_W-1:0]   err_data,
`endif
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] src_q, dst_q, idx, idx_nxt;
    logic [CNT_W-1:0]  rem;
    logic [LW-1:0]     lat;
    logic [DATA_W-1:0] pat, pat_nxt;
    logic              accept, last, rd_last, mismatch, pat_step;

    assign accept       = cmd_valid & cmd_ready;
    assign last         = rem == CNT_W'(1);
    assign rd_last      = lat == '0;
    assign idx_nxt      = idx + 1'b1;
    assign mismatch     = (state == S_CMP) && rd_last && (m_readdata != pat);
    assign pat_step     = (state == S_FILL) || ((state == S_CMP) && rd_last);
    assign m_byteenable = '1;

    hsys_mem_patgen #(.DATA_W(DATA_W)) u_patgen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .step    (pat_step),
        .pattern (cmd_pattern),
        .incr    (cmd_incr),
        .pat     (pat),
        .pat_nxt (pat_nxt)
    );

    // Job FSM; bus and status outputs are registered together with the state they belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            op_q         <= OP_FILL;
            src_q        <= '0;
            dst_q        <= '0;
            idx          <= '0;
            rem          <= '0;
            lat          <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_count    <= '0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_writedata  <= '0;
            m_clken      <= 1'b0;
        end else begin
            m_clken      <= 1'b1;
            done         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= ~accept;
                    if (accept) begin
                        busy      <= 1'b1;
                        err_count <= '0;
                        op_q      <= op_t'(cmd_op);
                        src_q     <= cmd_src;
                        dst_q     <= cmd_dst;
                        rem       <= cmd_len;
                        idx       <= '0;
                        if (cmd_len == '0 || cmd_op == OP_RSVD) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cmd_op == OP_FILL) begin
                            state        <= S_FILL;
                            m_chipselect <= 1'b1;
                            m_write      <= 1'b1;
                            m_address    <= cmd_dst;
                            m_writedata  <= cmd_pattern;
                        end else begin
                            state        <= S_RD;
                            m_chipselect <= 1'b1;
                            m_address    <= (cmd_op == OP_COPY) ? cmd_src : cmd_dst;
                        end
                    end
                end
                S_FILL: begin
                    rem <= rem - 1'b1;
                    idx <= idx_nxt;
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_address    <= dst_q + idx_nxt;
                        m_writedata  <= pat_nxt;
                    end
                end
                S_RD: begin
                    state <= (op_q == OP_COPY) ? S_RDW : S_CMP;
                    lat   <= LW'(RD_LAT - 1);
                end
                S_RDW: begin
                    if (!rd_last) begin
                        lat <= lat - 1'b1;
                    end else begin
                        state        <= S_WR;
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_address    <= dst_q + idx;
                        m_writedata  <= m_readdata;
                    end
                end
                S_WR: begin
                    rem <= rem - 1'b1;
                    idx <= idx_nxt;
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_RD;
                        m_chipselect <= 1'b1;
                        m_address    <= src_q + idx_nxt;
                    end
                end
                S_CMP: begin
                    if (!rd_last) begin
                        lat <= lat - 1'b1;
                    end else begin
                        if (mismatch && err_count != {CNT_W{1'b1}})
                            err_count <= err_count + 1'b1;
                        rem <= rem - 1'b1;
                        idx <= idx_nxt;
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_RD;
                            m_chipselect <= 1'b1;
                            m_address    <= dst_q + idx_nxt;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef HSYS_MEM_ERRLOG_EN
    // Keep the first mismatch of a CHECK job until another command is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_data  <= '0;
        end else if (accept) begin
            err_valid <= 1'b0;
        end else if (mismatch && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= dst_q + idx;
            err_data  <= m_readdata;
        end
    end
`endif

endmodule
